ai_exec_unit: RTL and testbench
===============================

Name: ai_exec_unit

Overview:
Parametrised, queued, multi-cycle AI execute unit that succeeds the fixed single-cycle AI datapath in the EX stage. It accepts AI ops from EX through a DEPTH-entry in-order request queue. Each op runs on a packed-SIMD datapath: LANES = XLEN/ELEM_W signed lanes, with one lane processed per cycle for dot-type ops. Results return through a valid/ready writeback port. A pending-destination mask feeds the hazard unit.

Parameters:
XLEN, 32, operand/result width; must be a multiple of ELEM_W.
ELEM_W, 8, signed element width per lane.
DEPTH, 4, request queue entries; power of two, minimum 2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
flush  in  1  synchronous pipeline flush.
req_valid  in  1  request valid.
req_ready  out  1  request ready.
req_op  in  3  opcode.
req_rd  in  5  destination register.
req_a  in  XLEN  operand A, packed lanes; lane 0 in the LSBs.
req_b  in  XLEN  operand B, packed lanes.
wb_valid  out  1  result valid.
wb_ready  in  1  result accepted.
wb_rd  out  5  result destination.
wb_data  out  XLEN  result.
wb_err  out  1  illegal opcode flag, qualified by wb_valid.
pending_rd  out  32  bit r set if any queued or in-flight op targets r; bit 0 is always 0.
busy  out  1  queue non-empty or FSM not IDLE.

Behaviour:
- Reset (reset=0 at a clk edge):
  - queue empty, FSM IDLE, accumulator ACC=0.
  - wb_valid=0, wb_rd=0, wb_data=0, wb_err=0, pending_rd=0, busy=0.
  - req_ready=0 during reset.
  - Reset mid-operation aborts everything; no writeback is produced.
- Request handshake:
  - req_ready = !full && !flush && reset.
  - An entry is pushed on req_valid && req_ready.
  - No bypass: a push in cycle T is visible to the FSM in T+1.
- Opcodes (signed two's-complement arithmetic):
  - 000 DOT: sum over lanes of a_i*b_i; products sign-extended to XLEN; result = sum.
  - 001 MAC: ACC <= ACC + dot(a,b); result = new ACC.
  - 010 RELU: result = a if a is signed non-negative, else 0.
  - 011 STEP: result = 1 if a > 0 (signed), else 0.
  - 100 CLRACC: ACC <= 0; result 0.
  - 101 LDACC: ACC <= a; result a.
  - 110/111: illegal; result 0, wb_err=1, ACC unchanged.
- FSM states: IDLE, EXEC, WB.
  - IDLE, queue non-empty: pop the head and latch op/rd/a/b. DOT/MAC go to EXEC with lane counter 0; all other ops go to WB.
  - EXEC: add lane[counter] product to a partial sum each cycle. After LANES cycles (counter == LANES-1), go to WB.
  - WB: wb_valid=1 and outputs held stable until wb_ready. On the handshake, return to IDLE; the next pop occurs the following cycle.
  - ACC updates on the transition into WB.
- Latency from a push in cycle T into an idle, empty unit:
  - RELU/STEP/CLRACC/LDACC/illegal: wb_valid asserted in T+2.
  - DOT/MAC: wb_valid asserted in T+2+LANES (T+6 at defaults).
- Arithmetic overflow: without the optional feature, the sum and ACC wrap modulo 2^XLEN.
- pending_rd is combinational: the OR of decoded rd over valid queue entries plus the in-flight entry (EXEC or WB).
- Full: req_ready=0 while the queue holds DEPTH entries; a pop in the same cycle does not raise it.
- Empty + IDLE: busy=0.
- Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer MSB.
- flush=1: in the next cycle the queue is empty, FSM IDLE, wb_valid=0 and pending_rd=0. ACC keeps any value already committed. A same-cycle request is rejected (req_ready=0). flush overrides a wb handshake in the same cycle.
- Ops with rd=0 execute and write back normally.

Optional Feature:
AI_EXEC_SAT_EN
- Defined: the DOT sum and the MAC accumulation saturate to the signed range [0x80..0, 0x7F..F] of XLEN bits. The saturated value is both the result and the new ACC.
- Undefined: wrap-around as described above.

Decomposition:
- Shared package ai_exec_pkg holds:
  - opcode localparams (OP_DOT..OP_LDACC);
  - FSM state encoding (S_IDLE/S_EXEC/S_WB);
  - width helper LANES = XLEN/ELEM_W.
- One sub-module, ai_req_fifo: parametrised DEPTH x (3+5+2*XLEN) synchronous FIFO with full/empty and per-entry valid/rd visibility for pending_rd.

Test Plan:
1. RELU a=0xFFFFFFF6, rd=5 -> wb_valid at T+2, wb_data=0, wb_rd=5. Then RELU a=0x00000007 -> wb_data=7. pending_rd[5]=1 until each handshake.
2. DOT a=0x01020304, b=0x01010101 -> wb_data=10 at T+6. DOT a=0xFF02FF04, b=0x02020202 -> wb_data=8.
3. CLRACC; MAC a=0x01020304, b=0x01010101 twice -> wb_data=10, then 20. Illegal op 110 -> wb_err=1, data 0, ACC stays 20.
4. Hold wb_ready=0 and push 5 RELU requests -> req_ready=0 after the 4 queued plus 1 in flight. wb outputs stable while stalled. Release wb_ready -> results drain in order with correct rd.
5. Assert flush while a DOT is in EXEC with 2 entries queued -> next cycle busy=0, pending_rd=0, and no writeback follows. Assert reset=0 mid-EXEC -> all outputs at reset values.
6. LDACC a=0x7FFFFFF0, then MAC a=0x7F7F7F7F, b=0x7F7F7F7F (dot=64516) -> with AI_EXEC_SAT_EN, wb_data=0x7FFFFFFF. Without the macro, wb_data=0x8000FBF4.

Source files
------------

// File: rtl/ai_exec_pkg.sv
// ai_exec_pkg: shared opcodes, FSM encoding and lane-count helper for ai_exec_unit
package ai_exec_pkg;
    localparam logic [2:0] OP_DOT    = 3'd0;
    localparam logic [2:0] OP_MAC    = 3'd1;
    localparam logic [2:0] OP_RELU   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_CLRACC = 3'd4;
    localparam logic [2:0] OP_LDACC  = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
    function automatic int lanes(input int xlen, input int elem_w);
        return xlen / elem_w;
    endfunction
endpackage

// File: rtl/ai_req_fifo.sv
// ai_req_fifo: in-order request queue {op, rd, a, b} with full/empty and a decoded mask of queued rds.
module ai_req_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [8+2*XLEN-1:0] wdata,
    output logic [8+2*XLEN-1:0] rdata,
    output logic                full,
    output logic                empty,
    output logic [31:0]         pend
);
    localparam int AW = $clog2(DEPTH);
    logic [8+2*XLEN-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic [AW-1:0] off;
    assign count = wptr - rptr;
    assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty = wptr == rptr;
    assign rdata = mem[rptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset && !flush && push && !full) mem[wptr[AW-1:0]] <= wdata;
    end
    // an entry is live when its distance from the read pointer is below the fill count
    always_comb begin
        pend = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr[AW-1:0];
            if ({1'b0, off} < count) pend[mem[i][2*XLEN +: 5]] = 1'b1;
        end
    end
endmodule

// File: rtl/ai_exec_unit.sv
// ai_exec_unit: queued multi-cycle packed-SIMD AI execute unit with valid/ready writeback.
// Define AI_EXEC_SAT_EN to saturate DOT sums and MAC accumulation instead of wrapping.
module ai_exec_unit
    import ai_exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ELEM_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_err,
    output logic [31:0]     pending_rd,
    output logic            busy
);
    localparam int LANES = lanes(XLEN, ELEM_W);
    localparam int SW = 2 * XLEN;
    localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
`ifdef AI_EXEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    state_t state, state_n;
    logic full, empty, pop, last;
    logic [8+2*XLEN-1:0] head;
    logic [31:0] fifo_pend;
    logic [2:0] h_op, op_q;
    logic [4:0] h_rd, rd_q;
    logic [XLEN-1:0] h_a, h_b, a_q, b_q, acc, acc_n, res_q, res_n;
    logic err_q;
    logic [CW-1:0] cnt;
    logic signed [ELEM_W-1:0] ea, eb;
    logic signed [SW-1:0] psum, prod, sum_n, mac_sum;

    // sums are kept at 2*XLEN so the saturation check sees the true value
    function automatic logic [XLEN-1:0] fit(input logic signed [SW-1:0] v);
        logic ovf;
        ovf = !(v[SW-1:XLEN-1] == '0 || v[SW-1:XLEN-1] == '1);
        return (SAT && ovf) ? (v[SW-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}})
                            : v[XLEN-1:0];
    endfunction

    assign req_ready = !full && !flush && reset;
    assign pop = state == S_IDLE && !empty && !flush;
    assign {h_op, h_rd, h_a, h_b} = head;

    ai_req_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (req_valid && req_ready),
        .pop   (pop),
        .wdata ({req_op, req_rd, req_a, req_b}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .pend  (fifo_pend)
    );

    assign ea = a_q[int'(cnt) * ELEM_W +: ELEM_W];
    assign eb = b_q[int'(cnt) * ELEM_W +: ELEM_W];
    assign prod = SW'(ea) * SW'(eb);
    assign sum_n = psum + prod;
    assign mac_sum = SW'($signed(acc)) + sum_n;
    assign last = cnt == CW'(LANES - 1);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (pop) state_n = (h_op == OP_DOT || h_op == OP_MAC) ? S_EXEC : S_WB;
            S_EXEC:  if (last) state_n = S_WB;
            S_WB:    if (wb_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    always_comb begin
        res_n = '0;
        acc_n = acc;
        if (state == S_EXEC) begin
            res_n = op_q == OP_MAC ? fit(mac_sum) : fit(sum_n);
            acc_n = op_q == OP_MAC ? res_n : acc;
        end else begin
            res_n = h_op == OP_RELU  ? (h_a[XLEN-1] ? '0 : h_a) :
                    h_op == OP_STEP  ? XLEN'($signed(h_a) > 0) :
                    h_op == OP_LDACC ? h_a : '0;
            acc_n = h_op == OP_CLRACC ? '0 : h_op == OP_LDACC ? h_a : acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q <= '0;
            rd_q <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
            psum <= '0;
            acc <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (pop) begin
                op_q <= h_op;
                rd_q <= h_rd;
                a_q <= h_a;
                b_q <= h_b;
                cnt <= '0;
                psum <= '0;
            end else if (state == S_EXEC) begin
                cnt <= cnt + 1'b1;
                psum <= sum_n;
            end
            // result and ACC commit only on entry to WB; flush forces IDLE so it never commits
            if (state_n == S_WB && state != S_WB) begin
                res_q <= res_n;
                err_q <= state == S_IDLE && h_op[2:1] == 2'b11;
                acc <= acc_n;
            end
        end
    end

    assign wb_valid = state == S_WB;
    assign wb_rd = wb_valid ? rd_q : '0;
    assign wb_data = wb_valid ? res_q : '0;
    assign wb_err = wb_valid && err_q;
    assign pending_rd = (fifo_pend | (state != S_IDLE ? 32'd1 << rd_q : 32'd0)) & ~32'd1;
    assign busy = !empty || state != S_IDLE;
endmodule

// File: tb/tb_ai_exec_unit.sv
// tb_ai_exec_unit: directed self-checking bench for ai_exec_unit at default parameters.
module tb_ai_exec_unit;
    logic clk = 1'b0, reset = 1'b0, flush = 1'b0, req_valid = 1'b0, wb_ready = 1'b0;
    logic req_ready, wb_valid, wb_err, busy;
    logic [2:0] req_op = '0;
    logic [4:0] req_rd = '0, wb_rd;
    logic [31:0] req_a = '0, req_b = '0, wb_data, pending_rd;
    logic seen;
    int n_cmp = 0, n_bad = 0;

    ai_exec_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
        .req_a(req_a), .req_b(req_b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
        .pending_rd(pending_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [2:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
        chk({tag, "_rdy"}, req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_rd = rd; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wbchk(input string tag, input logic [4:0] rd, input logic [31:0] data, input logic err);
        chk(tag, {wb_valid, wb_err, wb_rd, wb_data}, {1'b1, err, rd, data});
    endtask

    task automatic take();
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("reset_out", {wb_valid, wb_err, wb_rd, wb_data, busy, req_ready}, '0);
        chk("reset_pend", pending_rd, 32'h0);
        reset = 1'b1;
        cyc(1);
        // 1: RELU latency, pending tracking
        push("relu_neg", 3'b010, 5'd5, 32'hFFFFFFF6, 32'h0);
        chk("relu_t1", {wb_valid, busy}, 2'b01);
        chk("relu_pend_q", pending_rd, 32'h20);
        cyc(1);
        wbchk("relu_neg", 5'd5, 32'h0, 1'b0);
        chk("relu_pend_wb", pending_rd, 32'h20);
        take();
        chk("relu_after", {wb_valid, busy, pending_rd}, '0);
        push("relu_pos", 3'b010, 5'd5, 32'h7, 32'h0);
        cyc(1);
        wbchk("relu_pos", 5'd5, 32'h7, 1'b0);
        take();
        // STEP, including rd=0 which never shows in pending_rd
        push("step_pos", 3'b011, 5'd0, 32'h5, 32'h0);
        chk("step_pend_rd0", pending_rd, 32'h0);
        cyc(1);
        wbchk("step_pos", 5'd0, 32'h1, 1'b0);
        take();
        push("step_neg", 3'b011, 5'd9, 32'h80000000, 32'h0);
        cyc(1);
        wbchk("step_neg", 5'd9, 32'h0, 1'b0);
        take();
        // 2: DOT latency T+6
        push("dot1", 3'b000, 5'd1, 32'h01020304, 32'h01010101);
        cyc(4);
        chk("dot1_t5", wb_valid, 1'b0);
        cyc(1);
        wbchk("dot1", 5'd1, 32'd10, 1'b0);
        take();
        push("dot2", 3'b000, 5'd2, 32'hFF02FF04, 32'h02020202);
        cyc(5);
        wbchk("dot2", 5'd2, 32'd8, 1'b0);
        take();
        // 3: accumulator
        push("clracc", 3'b100, 5'd2, 32'h1234, 32'h0);
        cyc(1);
        wbchk("clracc", 5'd2, 32'h0, 1'b0);
        take();
        push("mac1", 3'b001, 5'd3, 32'h01020304, 32'h01010101);
        cyc(5);
        wbchk("mac1", 5'd3, 32'd10, 1'b0);
        take();
        push("mac2", 3'b001, 5'd3, 32'h01020304, 32'h01010101);
        cyc(5);
        wbchk("mac2", 5'd3, 32'd20, 1'b0);
        take();
        push("illegal", 3'b110, 5'd4, 32'h55, 32'h66);
        cyc(1);
        wbchk("illegal", 5'd4, 32'h0, 1'b1);
        take();
        push("mac_zero", 3'b001, 5'd3, 32'h0, 32'h0);
        cyc(5);
        wbchk("acc_kept", 5'd3, 32'd20, 1'b0);
        take();
        // 4: back-pressure and full queue
        for (int i = 0; i < 5; i++) push("bp", 3'b010, 5'(6 + i), 32'(6 + i), 32'h0);
        chk("bp_full", {req_ready, busy}, 2'b01);
        chk("bp_pend", pending_rd, 32'h000007C0);
        wbchk("bp_hold0", 5'd6, 32'd6, 1'b0);
        cyc(3);
        wbchk("bp_hold3", 5'd6, 32'd6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wbchk("bp_drain", 5'(6 + i), 32'(6 + i), 1'b0);
            take();
            if (i < 4) cyc(1);
        end
        chk("bp_done", {busy, pending_rd}, '0);
        // 5: flush mid-EXEC with two queued, then reset mid-EXEC
        push("fl_dot", 3'b000, 5'd11, 32'h01020304, 32'h01010101);
        push("fl_r12", 3'b010, 5'd12, 32'h1, 32'h0);
        push("fl_r13", 3'b010, 5'd13, 32'h1, 32'h0);
        chk("fl_pend", pending_rd, 32'h00003800);
        flush = 1'b1;
        #1;
        chk("fl_rdy", req_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_after", {busy, wb_valid, pending_rd}, '0);
        wb_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= wb_valid;
        end
        wb_ready = 1'b0;
        chk("fl_no_wb", seen, 1'b0);
        push("rs_dot", 3'b000, 5'd14, 32'h01020304, 32'h01010101);
        cyc(1);
        reset = 1'b0;
        #1;
        chk("rs_rdy", req_ready, 1'b0);
        @(negedge clk);
        chk("rs_out", {wb_valid, wb_err, wb_rd, wb_data, busy, req_ready}, '0);
        chk("rs_pend", pending_rd, 32'h0);
        reset = 1'b1;
        wb_ready = 1'b1;
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            seen |= wb_valid;
        end
        wb_ready = 1'b0;
        chk("rs_no_wb", seen, 1'b0);
        push("rs_acc", 3'b001, 5'd15, 32'h0, 32'h0);
        cyc(5);
        wbchk("rs_acc0", 5'd15, 32'h0, 1'b0);
        take();
        // 6: overflow
        push("ldacc", 3'b101, 5'd1, 32'h7FFFFFF0, 32'h0);
        cyc(1);
        wbchk("ldacc", 5'd1, 32'h7FFFFFF0, 1'b0);
        take();
        push("mac_ovf", 3'b001, 5'd1, 32'h7F7F7F7F, 32'h7F7F7F7F);
        cyc(5);
`ifdef AI_EXEC_SAT_EN
        wbchk("mac_ovf", 5'd1, 32'h7FFFFFFF, 1'b0);
`else
        wbchk("mac_ovf", 5'd1, 32'h8000FBF4, 1'b0);
`endif
        take();
        chk("end_idle", busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
